regfile_wb_ctrl: RTL and testbench

Controller for the 2R/1W integer register file. It arbitrates the single write port between the ALU writeback path and the load/store unit (LSU) writeback path, and buffers LSU results in a small FIFO. It also keeps a per-register pending-write scoreboard that stalls issue on RAW/WAW hazards. It sits between the execute/LSU stages and the register file write port.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/wb_fifo.sv | 45 ++++
 rtl/regfile_wb_ctrl.sv | 95 +++++++++
 tb/tb_regfile_wb_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file writeback types and constants
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef struct packed {
    reg_addr_t         rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;
  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small circular FIFO with valid/ready on both sides and a registered occupancy count
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  assign in_ready_o  = count_q != CW'(DEPTH);
  assign out_valid_o = count_q != '0;
  assign out_data_o  = mem_q[rd_ptr_q];
  always_comb begin
    push     = in_valid_i && in_ready_o;
    pop      = out_ready_i && out_valid_o;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: arbitrates the register-file write port between ALU and queued LSU results,
// and tracks outstanding writes per register to stall issue on RAW/WAW hazards.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int WIDTH          = DATA_W,
  parameter int NUM_REGS       = 32,
  parameter int LSU_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic                issue_writes,
  input  reg_addr_t           issue_rd,
  input  reg_addr_t           issue_rs1,
  input  reg_addr_t           issue_rs2,
  output logic                issue_stall,
  input  logic                alu_wb_valid,
  output logic                alu_wb_ready,
  input  reg_addr_t           alu_wb_rd,
  input  logic [WIDTH-1:0]    alu_wb_data,
  input  logic                lsu_wb_valid,
  output logic                lsu_wb_ready,
  input  reg_addr_t           lsu_wb_rd,
  input  logic [WIDTH-1:0]    lsu_wb_data,
  output logic                rf_write_en,
  output reg_addr_t           rf_write_addr,
  output logic [WIDTH-1:0]    rf_write_data,
  output logic [NUM_REGS-1:0] pending_mask
);
  localparam int EW = REG_ADDR_W + WIDTH;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);
  logic [NUM_REGS-1:0] pending_q, pending_d, set_mask, clr_mask;
  logic [SW-1:0]       starve_q, starve_d;
  logic [EW-1:0]       lsu_head;
  reg_addr_t           head_rd, wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]    head_data, wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d, fifo_ne, starved, lsu_grant, alu_grant, lsu_push;

  // rd==0 LSU results complete their handshake but never occupy a slot
  assign lsu_push = lsu_wb_valid && lsu_wb_rd != ZERO_REG;

  wb_fifo #(.DEPTH(LSU_FIFO_DEPTH), .W(EW)) u_lsu_fifo (
    .clk        (clk),
    .rst        (reset),
    .in_valid_i (lsu_push),
    .in_ready_o (lsu_wb_ready),
    .in_data_i  ({lsu_wb_rd, lsu_wb_data}),
    .out_valid_o(fifo_ne),
    .out_ready_i(lsu_grant),
    .out_data_o (lsu_head)
  );

  assign {head_rd, head_data} = lsu_head;
  assign starved       = fifo_ne && starve_q == SW'(STARVE_LIMIT);
  assign lsu_grant     = fifo_ne && (!alu_wb_valid || starved);
  assign alu_grant     = alu_wb_valid && !lsu_grant;
  assign alu_wb_ready  = !starved;
  assign issue_stall   = issue_valid && (pending_q[issue_rs1] || pending_q[issue_rs2] ||
                                         (issue_writes && pending_q[issue_rd]));
  assign rf_write_en   = wr_en_q;
  assign rf_write_addr = wr_addr_q;
  assign rf_write_data = wr_data_q;
  assign pending_mask  = pending_q;

  always_comb begin
    wr_en_d   = lsu_grant || (alu_grant && alu_wb_rd != ZERO_REG);
    wr_addr_d = !wr_en_d ? ZERO_REG : lsu_grant ? head_rd : alu_wb_rd;
    wr_data_d = !wr_en_d ? '0 : lsu_grant ? head_data : alu_wb_data;
    // a non-empty FIFO that is not granted means the ALU won, and never past the limit
    starve_d  = (!fifo_ne || lsu_grant) ? '0 : starve_q + 1'b1;
    set_mask  = (issue_valid && !issue_stall && issue_writes && issue_rd != ZERO_REG) ?
                ONE << issue_rd : '0;
    clr_mask  = wr_en_q ? ONE << wr_addr_q : '0;
    pending_d = ((pending_q & ~clr_mask) | set_mask) & ~ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      starve_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= ZERO_REG;
      wr_data_q <= '0;
    end else begin
      pending_q <= pending_d;
      starve_q  <= starve_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed scenarios plus randomized traffic checked every cycle
// against a queue-based behavioural model of the writeback controller.
module tb_regfile_wb_ctrl;
  localparam int LIM = 4;
  localparam int DEP = 2;
  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_writes, issue_stall;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        alu_wb_valid, alu_wb_ready;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        lsu_wb_valid, lsu_wb_ready;
  logic [4:0]  lsu_wb_rd;
  logic [31:0] lsu_wb_data;
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic [31:0] pending_mask;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  regfile_wb_ctrl dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_writes(issue_writes), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_stall(issue_stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready), .alu_wb_rd(alu_wb_rd),
    .alu_wb_data(alu_wb_data),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready), .lsu_wb_rd(lsu_wb_rd),
    .lsu_wb_data(lsu_wb_data),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .pending_mask(pending_mask)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;
  ent_t        mq[$];
  bit   [31:0] m_pend;
  int          m_starve;
  bit          m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_ok = 1'b0;

  function automatic bit exp_stall();
    return issue_valid && (m_pend[issue_rs1] || m_pend[issue_rs2] || (issue_writes && m_pend[issue_rd]));
  endfunction

  always @(posedge clk) begin
    int n;
    bit lt, acc, nw;
    logic [4:0] na;
    logic [31:0] nd;
    if (reset) begin
      mq.delete();
      m_pend = '0; m_starve = 0; m_en = 0; m_addr = '0; m_data = '0; m_ok = 1'b1;
    end else if (m_ok) begin
      n   = mq.size();
      lt  = n > 0 && (!alu_wb_valid || m_starve == LIM);
      acc = issue_valid && !exp_stall() && issue_writes && issue_rd != 0;
      nw = 0; na = '0; nd = '0;
      if (lt) begin
        nw = 1; na = mq[0].rd; nd = mq[0].data;
        mq.pop_front();
      end else if (alu_wb_valid && alu_wb_rd != 0) begin
        nw = 1; na = alu_wb_rd; nd = alu_wb_data;
      end
      m_starve = (n == 0 || lt) ? 0 : (m_starve < LIM ? m_starve + 1 : LIM);
      if (m_en) m_pend[m_addr] = 1'b0;
      if (acc) m_pend[issue_rd] = 1'b1;
      if (lsu_wb_valid && n < DEP && lsu_wb_rd != 0) mq.push_back('{lsu_wb_rd, lsu_wb_data});
      m_en = nw; m_addr = na; m_data = nd;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("issue_stall", issue_stall, exp_stall());
      chk("alu_wb_ready", alu_wb_ready, !(mq.size() > 0 && m_starve == LIM));
      chk("lsu_wb_ready", lsu_wb_ready, mq.size() < DEP);
      chk("rf_write_en", rf_write_en, m_en);
      if (m_en) begin
        chk("rf_write_addr", rf_write_addr, m_addr);
        chk("rf_write_data", rf_write_data, m_data);
      end
      chk("pending_mask", pending_mask, m_pend);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_writes = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
    lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_data = 0;
  endtask

  logic [31:0] wq[$];
  int          acc_cycle;
  bit          flag;
  int          ap, lp;

  initial begin
    idle();
    reset = 1;
    step(); step();
    reset = 0; #1;
    chk("rst_pending", pending_mask, 0);
    chk("rst_wen", rf_write_en, 0);
    chk("rst_waddr", rf_write_addr, 0);
    chk("rst_wdata", rf_write_data, 0);
    chk("rst_lsu_ready", lsu_wb_ready, 1);
    // RAW hazard on x5
    step(); issue_valid = 1; issue_writes = 1; issue_rd = 5; #1;
    chk("raw_issue_ok", issue_stall, 0);
    step(); issue_writes = 0; issue_rd = 6; issue_rs1 = 5;
    alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_data = 32'hDEAD; #1;
    chk("raw_pend", pending_mask, 32'h20);
    chk("raw_stall", issue_stall, 1);
    chk("raw_alu_ready", alu_wb_ready, 1);
    step(); alu_wb_valid = 0; #1;
    chk("raw_wen", rf_write_en, 1);
    chk("raw_waddr", rf_write_addr, 5);
    chk("raw_wdata", rf_write_data, 32'hDEAD);
    chk("raw_still_stall", issue_stall, 1);
    step(); #1;
    chk("raw_released", issue_stall, 0);
    chk("raw_pend_clr", pending_mask, 0);
    idle();
    // ALU/LSU collision
    step(); alu_wb_valid = 1; alu_wb_rd = 3; alu_wb_data = 32'hA3;
    lsu_wb_valid = 1; lsu_wb_rd = 4; lsu_wb_data = 32'hB4; #1;
    chk("col_lsu_ready", lsu_wb_ready, 1);
    step(); idle(); #1;
    chk("col_first_en", rf_write_en, 1);
    chk("col_first_addr", rf_write_addr, 3);
    step(); #1;
    chk("col_second_en", rf_write_en, 1);
    chk("col_second_addr", rf_write_addr, 4);
    chk("col_second_data", rf_write_data, 32'hB4);
    // starvation forcing
    step(); alu_wb_valid = 1; alu_wb_rd = 1; alu_wb_data = 0;
    lsu_wb_valid = 1; lsu_wb_rd = 9; lsu_wb_data = 32'hC9;
    step(); lsu_wb_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("starve_alu_ready", alu_wb_ready, 1);
      alu_wb_data = i;
      step();
    end
    #1 chk("starve_alu_blocked", alu_wb_ready, 0);
    step(); #1;
    chk("starve_lsu_addr", rf_write_addr, 9);
    chk("starve_lsu_data", rf_write_data, 32'hC9);
    chk("starve_alu_back", alu_wb_ready, 1);
    idle();
    // FIFO full with ALU busy on x0 (so every visible write is an LSU write)
    step(); alu_wb_valid = 1; alu_wb_rd = 0;
    lsu_wb_valid = 1; lsu_wb_rd = 10; lsu_wb_data = 32'h100; #1;
    chk("full_rdy0", lsu_wb_ready, 1);
    step(); lsu_wb_rd = 11; lsu_wb_data = 32'h101; #1;
    chk("full_rdy1", lsu_wb_ready, 1);
    step(); lsu_wb_rd = 12; lsu_wb_data = 32'h102; #1;
    chk("full_rdy2", lsu_wb_ready, 0);
    wq.delete();
    acc_cycle = -1;
    for (int c = 0; c < 40 && wq.size() < 3; c++) begin
      flag = lsu_wb_valid && lsu_wb_ready;
      if (flag) acc_cycle = c;
      step();
      if (flag) begin lsu_wb_valid = 0; alu_wb_valid = 0; end
      #1;
      if (rf_write_en) wq.push_back(rf_write_data);
    end
    chk("full_accept_cycle", acc_cycle, 4);
    chk("full_write_count", wq.size(), 3);
    if (wq.size() == 3)
      for (int i = 0; i < 3; i++) chk("full_order", wq[i], 32'h100 + i);
    idle();
    // x0 destination
    step(); issue_valid = 1; issue_writes = 1; issue_rd = 0;
    alu_wb_valid = 1; alu_wb_rd = 0; alu_wb_data = 32'h1234; #1;
    chk("x0_alu_ready", alu_wb_ready, 1);
    chk("x0_no_stall", issue_stall, 0);
    step(); idle(); #1;
    chk("x0_pend", pending_mask, 0);
    chk("x0_no_write", rf_write_en, 0);
    // reset mid-operation
    step(); issue_valid = 1; issue_writes = 1; issue_rd = 5;
    step(); issue_rd = 7; alu_wb_valid = 1; alu_wb_rd = 0;
    lsu_wb_valid = 1; lsu_wb_rd = 13; lsu_wb_data = 13;
    step(); issue_valid = 0; lsu_wb_rd = 14; lsu_wb_data = 14;
    step(); lsu_wb_valid = 0; alu_wb_rd = 2; alu_wb_data = 32'h22; #1;
    chk("mid_pend", pending_mask, 32'hA0);
    chk("mid_full", lsu_wb_ready, 0);
    reset = 1;
    step(); reset = 0; idle(); #1;
    chk("mid_rst_pend", pending_mask, 0);
    chk("mid_rst_lsu_ready", lsu_wb_ready, 1);
    chk("mid_rst_wen", rf_write_en, 0);
    for (int i = 0; i < 4; i++) begin
      step(); #1 chk("mid_no_stale", rf_write_en, 0);
    end
    // randomized traffic in four load mixes
    for (int c = 0; c < 4000; c++) begin
      step();
      ap = (c / 500) % 4 == 0 ? 30 : (c / 500) % 4 == 1 ? 90 : (c / 500) % 4 == 2 ? 100 : 50;
      lp = (c / 500) % 4 == 0 ? 30 : (c / 500) % 4 == 1 ? 40 : (c / 500) % 4 == 2 ? 70 : 90;
      reset        = $urandom_range(0, 299) == 0;
      issue_valid  = 1'($urandom_range(0, 1));
      issue_writes = 1'($urandom_range(0, 1));
      issue_rd     = 5'($urandom_range(0, 7));
      issue_rs1    = 5'($urandom_range(0, 7));
      issue_rs2    = 5'($urandom_range(0, 31));
      alu_wb_valid = $urandom_range(0, 99) < ap;
      alu_wb_rd    = 5'($urandom_range(0, 7));
      alu_wb_data  = $urandom;
      lsu_wb_valid = $urandom_range(0, 99) < lp;
      lsu_wb_rd    = 5'($urandom_range(0, 9));
      lsu_wb_data  = $urandom;
    end
    step(); reset = 0; idle();
    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
